// File: rtl/lab_test_pkg.sv
// Shared types, sizes and golden-table helper for the truth-table self-test sequencer.
package lab_test_pkg;

    localparam int unsigned N_IN     = 4;
    localparam int unsigned N_OUT    = 3;
    localparam int unsigned NUM_VEC  = 1 << N_IN;
    localparam int unsigned GOLDEN_W = N_OUT * NUM_VEC;
    localparam int unsigned CNT_W    = N_IN + 1;
    localparam int unsigned SETTLE_W = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        APPLY  = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_e;

    typedef logic [N_IN-1:0]     vec_t;
    typedef logic [N_OUT-1:0]    resp_t;
    typedef logic [CNT_W-1:0]    cnt_t;
    typedef logic [GOLDEN_W-1:0] golden_t;

    // Expected response for one vector, packed LSB-first by vector index
    function automatic resp_t golden_at(input golden_t golden, input vec_t idx);
        return golden[int'(idx) * N_OUT +: N_OUT];
    endfunction

endpackage

// File: rtl/truth_table_sequencer_if.sv
// Host/DUT-facing signal bundle of the truth-table sequencer.
interface truth_table_sequencer_if;
    import lab_test_pkg::*;

    logic  start;
    logic  abort;
    resp_t dut_resp;
    vec_t  vec_out;
    logic  busy;
    logic  done;
    logic  pass;
    cnt_t  err_count;
    logic  first_err_valid;
    vec_t  first_err_idx;

    modport master (
        output start, abort, dut_resp,
        input  vec_out, busy, done, pass, err_count, first_err_valid, first_err_idx
    );

    modport slave (
        input  start, abort, dut_resp,
        output vec_out, busy, done, pass, err_count, first_err_valid, first_err_idx
    );

endinterface

// File: rtl/settle_timer.sv
// Down-counter that holds each vector for LOAD_VAL cycles before the sample cycle.
module settle_timer
    import lab_test_pkg::*;
#(
    parameter logic [SETTLE_W-1:0] LOAD_VAL = SETTLE_W'(1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load_i,
    input  logic count_i,
    output logic expire_c_o
);

    logic [SETTLE_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= LOAD_VAL;
        end else if (count_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - SETTLE_W'(1);
        end
    end

    // Last settle cycle is the one where the count reads 1
    assign expire_c_o = count_i && (cnt_q == SETTLE_W'(1));

endmodule

// File: rtl/truth_table_sequencer.sv
// Sweeps every input vector into a combinational block, checks it against GOLDEN and reports results.
module truth_table_sequencer
    import lab_test_pkg::*;
#(
    parameter int unsigned SETTLE = 1,
    parameter golden_t     GOLDEN = '0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    truth_table_sequencer_if.slave  bus
);

    state_e state_q;
    vec_t   vec_q;
    logic   busy_q;
    logic   done_q;
    logic   pass_q;
    cnt_t   err_q;
    logic   fev_q;
    vec_t   fei_q;

    logic   start_acc_c;
    logic   last_vec_c;
    logic   mismatch_c;
    logic   timer_load_c;
    logic   timer_count_c;
    logic   timer_expire_c;

    assign start_acc_c   = bus.start && !bus.abort && ((state_q == IDLE) || (state_q == DONE));
    assign last_vec_c    = (vec_q == vec_t'(NUM_VEC - 1));
    // dut_resp only matters in SAMPLE, so an undriven response elsewhere is harmless
    assign mismatch_c    = (state_q == SAMPLE) && (bus.dut_resp != golden_at(GOLDEN, vec_q));
    assign timer_load_c  = start_acc_c || ((state_q == SAMPLE) && !last_vec_c && !bus.abort);
    assign timer_count_c = (state_q == APPLY) && !bus.abort;

    settle_timer #(
        .LOAD_VAL (SETTLE_W'(SETTLE))
    ) u_settle_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (timer_load_c),
        .count_i    (timer_count_c),
        .expire_c_o (timer_expire_c)
    );

    // Sequencer FSM with its vector counter and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            vec_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= '0;
            fev_q   <= 1'b0;
            fei_q   <= '0;
        end else if (bus.abort) begin
            state_q <= IDLE;
            vec_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= '0;
            fev_q   <= 1'b0;
            fei_q   <= '0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (bus.start) begin
                        state_q <= APPLY;
                        vec_q   <= '0;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                        pass_q  <= 1'b0;
                        err_q   <= '0;
                        fev_q   <= 1'b0;
                        fei_q   <= '0;
                    end
                end
                APPLY: begin
                    if (timer_expire_c) begin
                        state_q <= SAMPLE;
                    end
                end
                SAMPLE: begin
                    if (mismatch_c) begin
                        err_q <= err_q + CNT_W'(1);
                        if (!fev_q) begin
                            fev_q <= 1'b1;
                            fei_q <= vec_q;
                        end
                    end
                    if (last_vec_c) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        pass_q  <= (err_q == '0) && !mismatch_c;
                    end else begin
                        state_q <= APPLY;
                        vec_q   <= vec_q + N_IN'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.vec_out         = vec_q;
    assign bus.busy            = busy_q;
    assign bus.done            = done_q;
    assign bus.pass            = pass_q;
    assign bus.err_count       = err_q;
    assign bus.first_err_valid = fev_q;
    assign bus.first_err_idx   = fei_q;

endmodule

// File: tb/tb_truth_table_sequencer.sv
// Scoreboard bench: lab gate model as DUT, two sequencers (SETTLE=1 and SETTLE=3).
module tb_truth_table_sequencer;

    typedef struct packed {
        logic [3:0]  vec;
        logic [31:0] cyc;
    } vexp_t;

    typedef struct {
        int unsigned err;
        bit          fev;
        int unsigned fei;
        bit          pass;
    } rexp_t;

    function automatic logic [2:0] gates(input logic [3:0] v, input bit kill_h);
        logic a, b, c, d, f, g, h;
        a = v[3]; b = v[2]; c = v[1]; d = v[0];
        f = a ^ b;
        g = (a & c) | (b & ~c) | (a & b);
        h = d | (c & ~(a & b));
        if (kill_h) h = 1'b0;
        return {f, g, h};
    endfunction

    function automatic logic [47:0] build_golden();
        logic [47:0] gv;
        gv = '0;
        for (int i = 0; i < 16; i++) gv[i*3 +: 3] = gates(4'(i), 1'b0);
        return gv;
    endfunction

    localparam logic [47:0] GOLDEN = build_golden();

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    bit   fault = 1'b0;
    bit   sel = 1'b0;

    int unsigned n_vec = 0;
    int unsigned n_miss = 0;

    vexp_t vec_q[$];
    rexp_t res_q[$];

    always #5 clk = ~clk;

    truth_table_sequencer_if if1();
    truth_table_sequencer_if if3();

    assign if1.dut_resp = gates(if1.vec_out, fault);
    assign if3.dut_resp = gates(if3.vec_out, fault);

    truth_table_sequencer #(.SETTLE(1), .GOLDEN(GOLDEN)) u_dut1 (
        .clk (clk), .rst_n (rst_n), .bus (if1.slave)
    );

    truth_table_sequencer #(.SETTLE(3), .GOLDEN(GOLDEN)) u_dut3 (
        .clk (clk), .rst_n (rst_n), .bus (if3.slave)
    );

    logic [3:0] m_vec, m_fei;
    logic [4:0] m_err;
    logic [2:0] m_resp;
    logic       m_busy, m_done, m_pass, m_fev;

    assign m_vec  = sel ? if3.vec_out         : if1.vec_out;
    assign m_fei  = sel ? if3.first_err_idx   : if1.first_err_idx;
    assign m_err  = sel ? if3.err_count       : if1.err_count;
    assign m_resp = sel ? if3.dut_resp        : if1.dut_resp;
    assign m_busy = sel ? if3.busy            : if1.busy;
    assign m_done = sel ? if3.done            : if1.done;
    assign m_pass = sel ? if3.pass            : if1.pass;
    assign m_fev  = sel ? if3.first_err_valid : if1.first_err_valid;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic set_start(input bit v);
        if (sel) if3.start = v; else if1.start = v;
    endtask

    task automatic set_abort(input bit v);
        if (sel) if3.abort = v; else if1.abort = v;
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_vec"},  32'(m_vec),  0);
        chk({tag, "_busy"}, 32'(m_busy), 0);
        chk({tag, "_done"}, 32'(m_done), 0);
        chk({tag, "_pass"}, 32'(m_pass), 0);
        chk({tag, "_err"},  32'(m_err),  0);
        chk({tag, "_fev"},  32'(m_fev),  0);
        chk({tag, "_fei"},  32'(m_fei),  0);
    endtask

    task automatic pop_vec(input string tag, input int unsigned cyc);
        vexp_t e;
        if (vec_q.size() == 0) begin
            chk({tag, "_vec_underflow"}, 1, 0);
        end else begin
            e = vec_q.pop_front();
            chk({tag, "_vec_value"}, 32'(m_vec), 32'(e.vec));
            chk({tag, "_vec_cycle"}, cyc, e.cyc);
            if (!fault && m_vec == 4'b0101) chk({tag, "_resp_0101"}, 32'(m_resp), 32'(3'b111));
            if (!fault && m_vec == 4'b1110) chk({tag, "_resp_1110"}, 32'(m_resp), 32'(3'b010));
        end
    endtask

    // One full run; expectations queued at start, consumed as the DUT advances and finishes
    task automatic run_test(input string tag, input int unsigned settle, input bit extra_starts);
        int unsigned per;
        int unsigned done_cyc;
        bit          seen_done;
        logic [3:0]  last;
        rexp_t       r;
        rexp_t       got;
        vexp_t       e;
        per = settle + 1;
        done_cyc = 0;
        seen_done = 1'b0;
        r.err = 0; r.fev = 1'b0; r.fei = 0;
        for (int i = 0; i < 16; i++) begin
            e.vec = 4'(i);
            e.cyc = 32'(per * i);
            vec_q.push_back(e);
            if (gates(4'(i), fault) != GOLDEN[i*3 +: 3]) begin
                r.err++;
                if (!r.fev) begin r.fev = 1'b1; r.fei = i; end
            end
        end
        r.pass = (r.err == 0);
        res_q.push_back(r);

        @(negedge clk); set_start(1'b1);
        @(posedge clk); #1;
        last = m_vec;
        pop_vec(tag, 0);
        for (int cyc = 1; cyc <= 200 && !seen_done; cyc++) begin
            @(negedge clk); set_start(extra_starts && (cyc == 5 || cyc == 20));
            @(posedge clk); #1;
            if (m_busy && m_vec != last) begin
                pop_vec(tag, cyc);
                last = m_vec;
            end
            if (m_done) begin
                seen_done = 1'b1;
                done_cyc = cyc;
            end
        end
        @(negedge clk); set_start(1'b0);

        chk({tag, "_done_seen"},  32'(seen_done), 1);
        chk({tag, "_done_cycle"}, done_cyc, per * 16);
        chk({tag, "_vec_left"},   vec_q.size(), 0);
        vec_q.delete();
        got = res_q.pop_front();
        chk({tag, "_err_count"}, 32'(m_err),  got.err);
        chk({tag, "_first_fev"}, 32'(m_fev),  32'(got.fev));
        chk({tag, "_first_idx"}, 32'(m_fei),  got.fei);
        chk({tag, "_pass"},      32'(m_pass), 32'(got.pass));
        chk({tag, "_busy_end"},  32'(m_busy), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        if1.start = 1'b0; if1.abort = 1'b0;
        if3.start = 1'b0; if3.abort = 1'b0;

        repeat (3) @(posedge clk);
        #1 check_idle_outputs("reset");
        @(negedge clk); rst_n = 1'b1;

        run_test("clean", 1, 1'b0);

        fault = 1'b1;
        run_test("fault_h0", 1, 1'b1);
        fault = 1'b0;

        // Abort in the middle of the sweep
        @(negedge clk); set_start(1'b1);
        @(posedge clk);
        @(negedge clk); set_start(1'b0);
        repeat (8) @(posedge clk);
        @(negedge clk); set_abort(1'b1);
        @(posedge clk); #1;
        check_idle_outputs("abort");
        @(negedge clk); set_abort(1'b0);
        repeat (3) @(posedge clk);
        #1 chk("abort_stays_idle", 32'(m_busy), 0);
        run_test("after_abort", 1, 1'b0);

        // start and abort together from DONE: abort wins
        chk("pre_both_done", 32'(m_done), 1);
        @(negedge clk); set_start(1'b1); set_abort(1'b1);
        @(posedge clk); #1;
        chk("both_busy", 32'(m_busy), 0);
        chk("both_done", 32'(m_done), 0);
        chk("both_pass", 32'(m_pass), 0);
        @(negedge clk); set_start(1'b0); set_abort(1'b0);

        // Asynchronous reset in the middle of a SETTLE=3 sweep
        sel = 1'b1;
        @(negedge clk); set_start(1'b1);
        @(posedge clk);
        @(negedge clk); set_start(1'b0);
        repeat (9) @(posedge clk);
        #1 chk("pre_reset_vec", 32'(m_vec), 2);
        #1 rst_n = 1'b0;
        #1 check_idle_outputs("async_rst");
        @(negedge clk); rst_n = 1'b1;

        run_test("settle3", 3, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
